pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_if.sv | 37 +++
 rtl/pc_branch_unit.sv | 89 ++++++++
 tb/tb_pc_branch_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_branch_if.sv
// Bus bundle for pc_branch_unit: strobes and instruction in, PC and branch status out.
// Counter signals exist only when BRANCH_STATS_EN is defined.
interface pc_branch_if;
  // Strobes are single-cycle requests. They act only while busy is low and are
  // dropped otherwise; br_done is the one-cycle completion pulse for br_req.
  logic [15:0] IR;
  logic        BEN_I;
  logic [15:0] bus;
  logic        inc_pc;
  logic        ld_pc;
  logic        br_req;
  logic [15:0] PC;
  logic        busy;
  logic        br_done;
  logic        br_taken;
  logic [1:0]  dbg_state;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] nottaken_cnt;
`endif

  modport master (
    output IR, BEN_I, bus, inc_pc, ld_pc, br_req,
`ifdef BRANCH_STATS_EN
    input  taken_cnt, nottaken_cnt,
`endif
    input  PC, busy, br_done, br_taken, dbg_state
  );

  modport slave (
    input  IR, BEN_I, bus, inc_pc, ld_pc, br_req,
`ifdef BRANCH_STATS_EN
    output taken_cnt, nottaken_cnt,
`endif
    output PC, busy, br_done, br_taken, dbg_state
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with a three-state PC-relative branch resolver (IDLE/EVAL/DONE).
// Optional taken/not-taken statistics are enabled with macro BRANCH_STATS_EN.
module pc_branch_unit (
  input  logic        Clk,
  input  logic        Reset,
  pc_branch_if.slave  bif
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [8:0]  r_offset;
  logic        r_taken;
  logic [15:0] w_target;

  assign w_target = r_pc + {{7{r_offset[8]}}, r_offset};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!bif.ld_pc && bif.br_req) w_next_state = EVAL;
      EVAL:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Offset is captured at acceptance so later IR changes cannot move the target.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc     <= 16'h0000;
      r_offset <= 9'd0;
      r_taken  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bif.ld_pc) begin
            r_pc <= bif.bus;
          end else begin
            if (bif.inc_pc) r_pc <= r_pc + 16'd1;
            if (bif.br_req) r_offset <= bif.IR[8:0];
          end
        end
        EVAL: begin
          if (bif.BEN_I) r_pc <= w_target;
          r_taken <= bif.BEN_I;
        end
        default: ;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_nottaken_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_taken_cnt    <= 16'h0000;
      r_nottaken_cnt <= 16'h0000;
    end else if (r_state == EVAL) begin
      if (bif.BEN_I) begin
        if (r_taken_cnt != 16'hFFFF) r_taken_cnt <= r_taken_cnt + 16'd1;
      end else begin
        if (r_nottaken_cnt != 16'hFFFF) r_nottaken_cnt <= r_nottaken_cnt + 16'd1;
      end
    end
  end

  assign bif.taken_cnt    = r_taken_cnt;
  assign bif.nottaken_cnt = r_nottaken_cnt;
`endif

  assign bif.PC        = r_pc;
  assign bif.busy      = (r_state != IDLE);
  assign bif.br_done   = (r_state == DONE);
  assign bif.br_taken  = r_taken;
  assign bif.dbg_state = r_state;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed cycle table, stats sequence, and randomized
// stimulus against a countdown-based reference model.
module tb_pc_branch_unit;
  logic Clk;
  logic Reset;
  pc_branch_if bif ();

  pc_branch_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bif   (bif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        inc;
    logic        br;
    logic        ben;
    logic [15:0] ir;
    logic [15:0] bus;
    logic [15:0] e_pc;
    logic        e_busy;
    logic        e_done;
    logic        e_taken;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  // Reference model: busy_left counts remaining busy cycles after acceptance.
  logic [15:0] m_pc;
  int          m_left;
  logic [8:0]  m_off;
  logic        m_taken;
  int          m_tc;
  int          m_nc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic inc, input logic br,
                       input logic ben, input logic [15:0] ir, input logic [15:0] bus);
    @(negedge Clk);
    Reset      = rst;
    bif.ld_pc  = ld;
    bif.inc_pc = inc;
    bif.br_req = br;
    bif.BEN_I  = ben;
    bif.IR     = ir;
    bif.bus    = bus;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_step(input logic rst, input logic ld, input logic inc, input logic br,
                            input logic ben, input logic [15:0] ir, input logic [15:0] bus);
    if (rst) begin
      m_pc = 16'h0; m_left = 0; m_off = 9'h0; m_taken = 1'b0; m_tc = 0; m_nc = 0;
    end else if (m_left == 0) begin
      if (ld) m_pc = bus;
      else begin
        if (inc) m_pc = m_pc + 16'd1;
        if (br) begin m_off = ir[8:0]; m_left = 2; end
      end
    end else if (m_left == 2) begin
      if (ben) begin
        m_pc = m_pc + 16'($signed(m_off));
        if (m_tc < 65535) m_tc++;
      end else if (m_nc < 65535) m_nc++;
      m_taken = ben;
      m_left = 1;
    end else begin
      m_left = 0;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    Reset = 1'b1; bif.ld_pc = 1'b0; bif.inc_pc = 1'b0; bif.br_req = 1'b0;
    bif.BEN_I = 1'b0; bif.IR = 16'h0; bif.bus = 16'h0;

    //            rst   ld    inc   br    ben   ir        bus       pc        busy  done  taken
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h3000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0E05, 16'h0000, 16'h3000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01FF, 16'h0000, 16'h3005, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555, 16'h3005, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h3000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h01FE, 16'h0000, 16'h3000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h2FFE, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2FFE, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000, 16'h3000, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h01FE, 16'h0000, 16'h3000, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3000, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h3000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b1, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0E07, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h4001, 1'b1, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h4003, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h1234, 16'h4003, 1'b0, 1'b0, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4003, 1'b0, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h4003, 1'b1, 1'b0, 1'b1};
    vecs[28] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].inc, vecs[i].br, vecs[i].ben, vecs[i].ir, vecs[i].bus);
      check($sformatf("vec%0d_pc", i), bif.PC, vecs[i].e_pc);
      check($sformatf("vec%0d_busy", i), 16'(bif.busy), 16'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i), 16'(bif.br_done), 16'(vecs[i].e_done));
      check($sformatf("vec%0d_taken", i), 16'(bif.br_taken), 16'(vecs[i].e_taken));
    end

`ifdef BRANCH_STATS_EN
    // Two taken and one not-taken branch after a reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check("stats_rst_taken", bif.taken_cnt, 16'd0);
    check("stats_rst_nottaken", bif.nottaken_cnt, 16'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, (k != 1), 16'h0, 16'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    check("stats_taken", bif.taken_cnt, 16'd2);
    check("stats_nottaken", bif.nottaken_cnt, 16'd1);
`endif

    // Randomized phase against the reference model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_ld, r_inc, r_br, r_ben;
      logic [15:0] r_ir, r_bus;
      r_rst = ($urandom_range(0, 63) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_inc = ($urandom_range(0, 3) == 0);
      r_br  = ($urandom_range(0, 2) == 0);
      r_ben = 1'($urandom_range(0, 1));
      r_ir  = 16'($urandom);
      r_bus = 16'($urandom);
      drive(r_rst, r_ld, r_inc, r_br, r_ben, r_ir, r_bus);
      model_step(r_rst, r_ld, r_inc, r_br, r_ben, r_ir, r_bus);
      check("rnd_pc", bif.PC, m_pc);
      check("rnd_busy", 16'(bif.busy), 16'(m_left != 0));
      check("rnd_done", 16'(bif.br_done), 16'(m_left == 1));
      check("rnd_taken", 16'(bif.br_taken), 16'(m_taken));
`ifdef BRANCH_STATS_EN
      check("rnd_tcnt", bif.taken_cnt, 16'(m_tc));
      check("rnd_ncnt", bif.nottaken_cnt, 16'(m_nc));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
